// File: rtl/ise_sort_engine_p.sv
// Image sorting engine: classifies each streamed image by dominant colour and emits a sorted index list.
// Optional output back-pressure (out_ready port) is enabled by defining ISE_OUT_READY_EN.
module ise_sort_engine_p #(
  parameter int IMG_NUM  = 32,
  parameter int IMG_SIZE = 128,
  parameter int CH_W     = 8,
  parameter int IDX_W    = $clog2(IMG_NUM)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [IDX_W-1:0]     image_in_index,
  input  logic [3*CH_W-1:0]    pixel_in,
  output logic                 busy,
  output logic                 out_valid,
  output logic [1:0]           color_index,
  output logic [IDX_W-1:0]     image_out_index
`ifdef ISE_OUT_READY_EN
  ,
  input  logic                 out_ready
`endif
);

  localparam int PIX_W = 2 * $clog2(IMG_SIZE);
  localparam int CNT_W = PIX_W + 1;
  localparam int TC_W  = IDX_W + 1;
  localparam logic [PIX_W-1:0] PIX_LAST = {PIX_W{1'b1}};

  typedef enum logic [1:0] {ST_ACC, ST_INS, ST_OUT} state_t;

  typedef struct packed {
    logic [1:0]       color;
    logic [CNT_W-1:0] strength;
    logic [IDX_W-1:0] idx;
  } entry_t;

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  pix_cnt;
  logic [CNT_W-1:0]  cnt_r, cnt_g, cnt_b;
  logic [IDX_W-1:0]  cur_idx;
  logic [TC_W-1:0]   tbl_cnt;
  logic [IDX_W-1:0]  out_ptr;
  logic [1:0]        hold_color;
  logic [IDX_W-1:0]  hold_idx;
  entry_t            tbl      [IMG_NUM];
  entry_t            tbl_next [IMG_NUM];
  entry_t            new_entry;
  logic [IMG_NUM-1:0] goes_before;
  logic [1:0]        dom;
  logic              accept;
  logic              out_ready_i;

`ifdef ISE_OUT_READY_EN
  assign out_ready_i = out_ready;
`else
  assign out_ready_i = 1'b1;
`endif

  logic [CH_W-1:0] px_r, px_g, px_b;
  assign px_r   = pixel_in[3*CH_W-1:2*CH_W];
  assign px_g   = pixel_in[2*CH_W-1:CH_W];
  assign px_b   = pixel_in[CH_W-1:0];
  assign accept = in_valid && (state_q == ST_ACC);

  // Dominant channel of the incoming pixel, ties resolved R over G over B.
  always_comb begin
    if (px_r >= px_g && px_r >= px_b) dom = 2'd0;
    else if (px_g >= px_b)            dom = 2'd1;
    else                              dom = 2'd2;
  end

  // Classification of the finished image from its channel counters.
  always_comb begin
    new_entry.idx = cur_idx;
    if (cnt_r >= cnt_g && cnt_r >= cnt_b) begin
      new_entry.color    = 2'd0;
      new_entry.strength = cnt_r;
    end else if (cnt_g >= cnt_b) begin
      new_entry.color    = 2'd1;
      new_entry.strength = cnt_g;
    end else begin
      new_entry.color    = 2'd2;
      new_entry.strength = cnt_b;
    end
  end

  // Strict ordering: equal keys return 0 so a later arrival lands after earlier ones.
  function automatic logic key_less(input entry_t a, input entry_t b);
    if (a.color != b.color)       return a.color < b.color;
    if (a.strength != b.strength) return a.strength > b.strength;
    return a.idx < b.idx;
  endfunction

  // goes_before is a suffix mask: empty slots and all entries ranked after the new one.
  always_comb begin
    for (int i = 0; i < IMG_NUM; i++)
      goes_before[i] = (TC_W'(i) >= tbl_cnt) || key_less(new_entry, tbl[i]);
  end

  always_comb begin
    tbl_next[0] = goes_before[0] ? new_entry : tbl[0];
    for (int i = 1; i < IMG_NUM; i++) begin
      if (!goes_before[i])        tbl_next[i] = tbl[i];
      else if (!goes_before[i-1]) tbl_next[i] = new_entry;
      else                        tbl_next[i] = tbl[i-1];
    end
  end

  // NOTE: the table is not reset; tbl_cnt and the FSM guarantee no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (state_q == ST_INS) tbl <= tbl_next;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_ACC;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      ST_ACC: begin
        busy = 1'b0;
        if (accept && pix_cnt == PIX_LAST) state_d = ST_INS;
      end
      ST_INS: state_d = (tbl_cnt == TC_W'(IMG_NUM - 1)) ? ST_OUT : ST_ACC;
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready_i && out_ptr == IDX_W'(IMG_NUM - 1)) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_cnt    <= '0;
      cnt_r      <= '0;
      cnt_g      <= '0;
      cnt_b      <= '0;
      cur_idx    <= '0;
      tbl_cnt    <= '0;
      out_ptr    <= '0;
      hold_color <= '0;
      hold_idx   <= '0;
    end else begin
      if (accept) begin
        pix_cnt <= pix_cnt + PIX_W'(1);
        if (pix_cnt == '0) cur_idx <= image_in_index;
        case (dom)
          2'd0:    cnt_r <= cnt_r + CNT_W'(1);
          2'd1:    cnt_g <= cnt_g + CNT_W'(1);
          default: cnt_b <= cnt_b + CNT_W'(1);
        endcase
      end
      if (state_q == ST_INS) begin
        cnt_r   <= '0;
        cnt_g   <= '0;
        cnt_b   <= '0;
        tbl_cnt <= tbl_cnt + TC_W'(1);
      end
      if (state_q == ST_OUT && out_ready_i) begin
        hold_color <= tbl[out_ptr].color;
        hold_idx   <= tbl[out_ptr].idx;
        out_ptr    <= out_ptr + IDX_W'(1);
        if (out_ptr == IDX_W'(IMG_NUM - 1)) tbl_cnt <= '0;
      end
    end
  end

  // Outputs show the current entry while emitting and the last emitted entry otherwise.
  assign color_index     = out_valid ? tbl[out_ptr].color : hold_color;
  assign image_out_index = out_valid ? tbl[out_ptr].idx   : hold_idx;

endmodule

// File: tb/tb_ise_sort_engine_p.sv
// Self-checking bench for ise_sort_engine_p: random batches against a queue-based sorting model,
// with a scoreboard monitor that pops expected entries whenever the DUT presents a result.
module tb_ise_sort_engine_p;

  localparam int IMG_NUM  = 4;
  localparam int IMG_SIZE = 2;
  localparam int CH_W     = 8;
  localparam int IDX_W    = 2;
  localparam int NPIX     = IMG_SIZE * IMG_SIZE;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [IDX_W-1:0]  image_in_index = '0;
  logic [3*CH_W-1:0] pixel_in = '0;
  logic              busy, out_valid;
  logic [1:0]        color_index;
  logic [IDX_W-1:0]  image_out_index;
`ifdef ISE_OUT_READY_EN
  logic              out_ready = 1'b1;
`endif

  ise_sort_engine_p #(
    .IMG_NUM(IMG_NUM), .IMG_SIZE(IMG_SIZE), .CH_W(CH_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .image_in_index(image_in_index),
    .pixel_in(pixel_in),
    .busy(busy),
    .out_valid(out_valid),
    .color_index(color_index),
    .image_out_index(image_out_index)
`ifdef ISE_OUT_READY_EN
    ,
    .out_ready(out_ready)
`endif
  );

  always #5 clk = ~clk;

`ifdef ISE_OUT_READY_EN
  always @(posedge clk) #1 out_ready = ($urandom_range(0, 3) != 0);
`endif

  typedef struct { int color; int strength; int idx; } res_t;

  res_t     exp_q[$];
  res_t     batch_q[$];
  int       checks = 0;
  int       failures = 0;
  bit       gaps = 1'b0;
  bit       tog = 1'b0;
  bit [23:0] img_px [IMG_NUM][NPIX];
  int        img_idx[IMG_NUM];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index of the largest of three values, earliest wins on ties.
  function automatic int argmax3(input int a, input int b, input int c);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (a == m) return 0;
    if (b == m) return 1;
    return 2;
  endfunction

  function automatic bit precedes(input int j, input int i);
    res_t a = batch_q[j];
    res_t b = batch_q[i];
    if (a.color != b.color)       return a.color < b.color;
    if (a.strength != b.strength) return a.strength > b.strength;
    if (a.idx != b.idx)           return a.idx < b.idx;
    return j < i;
  endfunction

  function automatic void model_image(input int k);
    int   cnt[3] = '{0, 0, 0};
    res_t r;
    for (int p = 0; p < NPIX; p++)
      cnt[argmax3(img_px[k][p][23:16], img_px[k][p][15:8], img_px[k][p][7:0])]++;
    r.color    = argmax3(cnt[0], cnt[1], cnt[2]);
    r.strength = cnt[r.color];
    r.idx      = img_idx[k];
    batch_q.push_back(r);
    if (batch_q.size() == IMG_NUM) begin
      for (int pos = 0; pos < IMG_NUM; pos++)
        for (int i = 0; i < IMG_NUM; i++) begin
          int rank = 0;
          for (int j = 0; j < IMG_NUM; j++)
            if (j != i && precedes(j, i)) rank++;
          if (rank == pos) exp_q.push_back(batch_q[i]);
        end
      batch_q.delete();
    end
  endfunction

  // Streams image k; junk is driven with in_valid=1 whenever busy, to show it is ignored.
  task automatic send_image(input int k, input bit last_of_batch);
    int p = 0;
    int budget = 0;
    while (p < NPIX) begin
      @(negedge clk);
      budget++;
      if (budget > 300) begin
        check("stream_timeout", budget, 0);
        return;
      end
      if (busy) begin
        in_valid = 1'b1;
        pixel_in = 24'($urandom);
        image_in_index = IDX_W'($urandom);
      end else if (gaps && tog) begin
        tog = 1'b0;
        in_valid = 1'b0;
        pixel_in = 24'($urandom);
        image_in_index = IDX_W'($urandom);
      end else begin
        tog = 1'b1;
        in_valid = 1'b1;
        pixel_in = img_px[k][p];
        image_in_index = IDX_W'(img_idx[k]);
        p++;
      end
    end
    model_image(k);
    @(negedge clk);
    in_valid = 1'b1;
    pixel_in = 24'($urandom);
    check("busy_ins", int'(busy), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_ins", int'(busy), last_of_batch ? 1 : 0);
  endtask

  function automatic bit [7:0] rand_ch();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'h80;
      2:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic void fill_random();
    for (int k = 0; k < IMG_NUM; k++) begin
      img_idx[k] = $urandom_range(0, IMG_NUM - 1);
      for (int p = 0; p < NPIX; p++) img_px[k][p] = {rand_ch(), rand_ch(), rand_ch()};
    end
  endfunction

  function automatic void fill_uniform(input int k, input int idx, input bit [23:0] px);
    img_idx[k] = idx;
    for (int p = 0; p < NPIX; p++) img_px[k][p] = px;
  endfunction

  task automatic run_batch();
    for (int k = 0; k < IMG_NUM; k++) send_image(k, k == IMG_NUM - 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", int'(n < 200), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_color", int'(color_index), 0);
    check("rst_index", int'(image_out_index), 0);
    batch_q.delete();
    exp_q.delete();
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  bit        prev_valid = 1'b0;
  int        last_c = 0, last_i = 0, run = 0;
  bit        prev_stall = 1'b0;
  int        stall_c = 0, stall_i = 0;
  always @(negedge clk) begin
    bit   hs;
    res_t e;
    if (!reset) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
      last_c = 0;
      last_i = 0;
      run = 0;
    end else if (out_valid) begin
`ifdef ISE_OUT_READY_EN
      hs = out_ready;
      if (prev_stall) begin
        check("stall_color", int'(color_index), stall_c);
        check("stall_index", int'(image_out_index), stall_i);
      end
`else
      hs = 1'b1;
`endif
      check("busy_in_out", int'(busy), 1);
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_color", int'(color_index), e.color);
          check("out_index", int'(image_out_index), e.idx);
        end
        last_c = int'(color_index);
        last_i = int'(image_out_index);
      end
      prev_stall = !hs;
      stall_c = int'(color_index);
      stall_i = int'(image_out_index);
      run++;
      prev_valid = 1'b1;
    end else begin
      if (prev_valid) begin
        check("busy_after_out", int'(busy), 0);
`ifndef ISE_OUT_READY_EN
        check("out_run_length", run, IMG_NUM);
`endif
      end
      check("hold_color", int'(color_index), last_c);
      check("hold_index", int'(image_out_index), last_i);
      run = 0;
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end
  end

  initial begin
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_color", int'(color_index), 0);
    check("reset_index", int'(image_out_index), 0);
    @(negedge clk);
    #2 reset = 1'b1;

    // Single-colour images: expected (0,0),(0,3),(1,1),(2,2).
    fill_uniform(0, 0, 24'hFF0000);
    fill_uniform(1, 1, 24'h00FF00);
    fill_uniform(2, 2, 24'h0000FF);
    fill_uniform(3, 3, 24'hFF0000);
    run_batch();
    drain();

    // Count tie R=G=2 resolves to red, strength 2, behind the strength-4 red image.
    fill_uniform(0, 0, 24'h0000FF);
    fill_uniform(1, 1, 24'hFF0000);
    fill_uniform(2, 2, 24'h00FF00);
    img_px[2][0] = 24'h808080;
    img_px[2][1] = 24'h808080;
    fill_uniform(3, 3, 24'h00FF00);
    run_batch();
    drain();

    // Toggled in_valid.
    gaps = 1'b1;
    fill_uniform(0, 2, 24'h00FF00);
    fill_uniform(1, 0, 24'hFF0000);
    fill_uniform(2, 3, 24'h0000FF);
    fill_uniform(3, 1, 24'h00FF00);
    run_batch();
    drain();
    gaps = 1'b0;

    // Abort after two images, then a clean batch.
    fill_random();
    send_image(0, 1'b0);
    send_image(1, 1'b0);
    pulse_reset();
    fill_random();
    run_batch();
    drain();

    // Back-to-back batches, then random batches with random gap mode.
    fill_random();
    run_batch();
    fill_random();
    run_batch();
    drain();
    for (int b = 0; b < 8; b++) begin
      gaps = 1'($urandom_range(0, 1));
      fill_random();
      run_batch();
      drain();
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
